// File: rtl/nonce_sweep_scheduler.sv
// Walks an inclusive, possibly wrapping nonce range, issuing one hash-core job per
// nonce and stopping on the first hash strictly below target, exhaustion, abort or timeout.
module nonce_sweep_scheduler #(
    parameter int NONCE_W     = 32,
    parameter int HASH_W      = 256,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_first,
    input  logic [NONCE_W-1:0] nonce_last,
    input  logic [HASH_W-1:0]  target,
    output logic               core_start,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_valid,
    input  logic [HASH_W-1:0]  core_hash,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [HASH_W-1:0]  found_hash,
    output logic               timeout_err,
    output logic [NONCE_W-1:0] tried_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CMP    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [2:0]         state_reg;
    logic [NONCE_W-1:0] cur_nonce_reg;
    logic [NONCE_W-1:0] last_reg;
    logic [HASH_W-1:0]  target_reg;
    logic [HASH_W-1:0]  hash_q_reg;
    logic [TMO_W-1:0]   tmo_reg;
    logic               found_reg;
    logic [NONCE_W-1:0] found_nonce_reg;
    logic [HASH_W-1:0]  found_hash_reg;
    logic               timeout_err_reg;
    logic [NONCE_W-1:0] tried_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            cur_nonce_reg   <= '0;
            last_reg        <= '0;
            target_reg      <= '0;
            hash_q_reg      <= '0;
            tmo_reg         <= '0;
            found_reg       <= 1'b0;
            found_nonce_reg <= '0;
            found_hash_reg  <= '0;
            timeout_err_reg <= 1'b0;
            tried_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        cur_nonce_reg   <= nonce_first;
                        last_reg        <= nonce_last;
                        target_reg      <= target;
                        found_reg       <= 1'b0;
                        found_nonce_reg <= '0;
                        found_hash_reg  <= '0;
                        timeout_err_reg <= 1'b0;
                        tried_reg       <= '0;
                        state_reg       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        state_reg <= S_FINISH;
                    end else begin
                        tmo_reg   <= '0;
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    tmo_reg <= tmo_reg + TMO_W'(1);
                    // A result landing in the same cycle as abort/timeout is still compared.
                    if (core_valid) begin
                        hash_q_reg <= core_hash;
                        state_reg  <= S_CMP;
                    end else if (abort) begin
                        state_reg <= S_FINISH;
                    end else if (tmo_reg == TMO_LAST) begin
                        timeout_err_reg <= 1'b1;
                        state_reg       <= S_FINISH;
                    end
                end
                S_CMP: begin
                    tried_reg <= tried_reg + NONCE_W'(1);
                    if (hash_q_reg < target_reg) begin
                        found_reg       <= 1'b1;
                        found_nonce_reg <= cur_nonce_reg;
                        found_hash_reg  <= hash_q_reg;
                        state_reg       <= S_FINISH;
                    end else if (cur_nonce_reg == last_reg) begin
                        state_reg <= S_FINISH;
                    end else begin
                        // Natural wrap of the increment gives the modulo-2^N sweep.
                        cur_nonce_reg <= cur_nonce_reg + NONCE_W'(1);
                        state_reg     <= S_ISSUE;
                    end
                end
                S_FINISH: state_reg <= S_IDLE;
                default:  state_reg <= S_IDLE;
            endcase
        end
    end

    assign core_start  = (state_reg == S_ISSUE) && !abort;
    assign core_nonce  = cur_nonce_reg;
    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_FINISH);
    assign found       = found_reg;
    assign found_nonce = found_nonce_reg;
    assign found_hash  = found_hash_reg;
    assign timeout_err = timeout_err_reg;
    assign tried_cnt   = tried_reg;

endmodule

// File: doc/nonce_sweep_scheduler.md
Name: nonce_sweep_scheduler

Overview:
Sequences a nonce search over an inclusive range [nonce_first, nonce_last]. For each nonce it issues one job to the double-SHA256 hash core and waits for the result. It then compares the hash against the target in a registered compare stage and stops on the first hash that is below the target, on range exhaustion, on abort, or on a core timeout. It sits between the job/UART control logic and the hash core, replacing free-running enable-based comparison with an explicit handshake.

Parameters:
NONCE_W, 32, nonce width in bits
HASH_W, 256, hash and target width
TIMEOUT_CYC, 1024, maximum cycles to wait for core_valid before flagging an error

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sweep; ignored unless in IDLE
abort  in  1  level; terminates the sweep at the next state evaluation
nonce_first  in  NONCE_W  first nonce; sampled on start
nonce_last  in  NONCE_W  last nonce, inclusive; sampled on start
target  in  HASH_W  difficulty target; sampled on start
core_start  out  1  one-cycle pulse to the hash core
core_nonce  out  NONCE_W  nonce for the current job; stable from core_start until core_valid
core_valid  in  1  one-cycle pulse from the hash core; result ready
core_hash  in  HASH_W  hash result; valid when core_valid=1
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at sweep end
found  out  1  sticky until the next start; a hash below target was found
found_nonce  out  NONCE_W  nonce that produced the winning hash
found_hash  out  HASH_W  winning hash
timeout_err  out  1  sticky until the next start; core did not respond in time
tried_cnt  out  NONCE_W  number of hashes compared in this sweep

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0: core_start, core_nonce, busy, done, found, found_nonce, found_hash, timeout_err, tried_cnt. Internal regs are cleared.
- Reset mid-sweep: the sweep is aborted immediately with no done pulse. Any late core_valid is ignored because the block is in IDLE.
- States: IDLE, ISSUE, WAIT, CMP, FINISH.
- IDLE, start=1:
  - Latch nonce_first into cur_nonce and latch nonce_last and target.
  - Clear found, found_nonce, found_hash, timeout_err and tried_cnt.
  - Go to ISSUE.
  - start is ignored in every state other than IDLE.
- ISSUE:
  - If abort=1, go to FINISH.
  - Otherwise assert core_start for exactly this one cycle, drive core_nonce=cur_nonce, clear the timeout counter, and go to WAIT.
- WAIT:
  - The timeout counter increments every cycle.
  - On core_valid=1, register core_hash into hash_q and go to CMP. core_valid takes priority over abort and timeout in the same cycle.
  - Else if abort=1, go to FINISH.
  - Else if the counter reaches TIMEOUT_CYC-1, set timeout_err=1 and go to FINISH.
- CMP (one cycle, compares the registered hash_q):
  - Increment tried_cnt.
  - If hash_q < target (unsigned, strict), set found=1, found_nonce=cur_nonce, found_hash=hash_q, and go to FINISH. hash_q == target is a miss.
  - Else if cur_nonce == nonce_last, go to FINISH (range exhausted).
  - Else cur_nonce <= cur_nonce+1 and go to ISSUE.
  - abort is not sampled in CMP. A find in CMP wins over an abort.
- FINISH: pulse done for one cycle, go to IDLE. busy falls in the same cycle IDLE is entered.
- Throughput: each nonce takes 3 cycles plus the core latency (ISSUE, WAIT≥1, CMP).
- Wrap-around:
  - nonce_first > nonce_last is a valid sweep that wraps modulo 2^NONCE_W. It covers first..max, then 0..last.
  - nonce_first == nonce_last is exactly one hash.
  - A full 2^NONCE_W sweep is expressed as last = first-1.
- core_valid arriving outside WAIT is ignored.

Test Plan:
1. Core responds with a 5-cycle latency; first=0x10, last=0x13, target=2^255. Core returns hashes with MSB=1 for 0x10 and 0x11, and 0x0...01 for 0x12 -> found=1, found_nonce=0x12, tried_cnt=3, done pulses once, core_start pulses 3 times, 0x13 is never issued.
2. Same range, every hash ≥ target, including one hash exactly equal to target -> found=0, tried_cnt=4, done=1 after the nonce 0x13 compare, busy low afterwards.
3. Wrap: first=0xFFFFFFFE, last=0x00000001, no hit -> core_nonce sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; tried_cnt=4.
4. Core never asserts core_valid, TIMEOUT_CYC=16 -> timeout_err=1 exactly 16 cycles after core_start, done pulses, found=0, tried_cnt=0.
5. abort asserted during WAIT of the 2nd nonce -> done pulses with tried_cnt=1. A second variant asserts abort together with core_valid in the same cycle -> the result is compared first and tried_cnt=2.
6. rst_n pulled low during WAIT, then released, then a stray core_valid arrives -> all outputs 0, state IDLE, no done. A new start then runs normally; start pulses during busy are ignored.
